// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage state encoding, E/M payload layout and the nop bubble value
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stage_state_e;

    localparam int CMP_W  = 1;
    localparam int PC_W   = 32;
    localparam int RT_W   = 32;
    localparam int ALU_W  = 32;
    localparam int INSTR_W = 32;

    localparam int CMP_OFS   = 0;
    localparam int PC_OFS    = CMP_OFS + CMP_W;
    localparam int RT_OFS    = PC_OFS + PC_W;
    localparam int ALU_OFS   = RT_OFS + RT_W;
    localparam int INSTR_OFS = ALU_OFS + ALU_W;

    localparam int PIPE_PAYLOAD_W = INSTR_OFS + INSTR_W;

    localparam logic [PIPE_PAYLOAD_W-1:0] NOP = '0;

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: 32-bit counter with enable that sticks at all-ones
module pipe_sat_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] cnt
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // advance only while enabled and not already saturated
    always_comb begin
        cnt_d = (en && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
    end

    // count register, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with skid entry and flush; stall/flush counters under PIPE_STAGE_STATS_EN
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                   PAYLOAD_W  = PIPE_PAYLOAD_W,
    parameter logic [PAYLOAD_W-1:0] BUBBLE_VAL = PAYLOAD_W'(NOP)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    input  logic                 flush,
    output logic [31:0]          stat_stall_cnt,
    output logic [31:0]          stat_flush_cnt
);

    stage_state_e         state_q, state_d;
    logic [PAYLOAD_W-1:0] main_q, main_d;
    logic [PAYLOAD_W-1:0] skid_q, skid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 accept;
    logic                 emit;

    assign accept = in_valid & in_ready_q;
    assign emit   = out_valid_q & out_ready;

    // next-state and storage update; flush overrides every handshake outcome
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) begin
                    state_d = FULL;
                    main_d  = in_payload;
                end
                FULL: if (accept && emit) begin
                    main_d = in_payload;
                end else if (accept) begin
                    state_d = SKID;
                    skid_d  = in_payload;
                end else if (emit) begin
                    state_d = EMPTY;
                end
                SKID: if (emit) begin
                    state_d = FULL;
                    main_d  = skid_q;
                    skid_d  = BUBBLE_VAL;
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d  = state_d != SKID;
        out_valid_d = state_d != EMPTY;
    end

    // handshake outputs are decoded from the next state so they leave flops directly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_q      <= BUBBLE_VAL;
            skid_q      <= BUBBLE_VAL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_payload = out_valid_q ? main_q : BUBBLE_VAL;

`ifdef PIPE_STAGE_STATS_EN
    logic stall_en;
    logic flush_en;

    assign stall_en = out_valid_q & ~out_ready;
    assign flush_en = flush & (state_q != EMPTY);

    pipe_sat_counter u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall_en),
        .cnt   (stat_stall_cnt)
    );

    pipe_sat_counter u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (flush_en),
        .cnt   (stat_flush_cnt)
    );
`else
    assign stat_stall_cnt = '0;
    assign stat_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: table-driven check of streaming, skid, flush, async reset and stats
module tb_pipe_stage_reg;

    localparam int W = 129;

    typedef struct {
        logic         iv;
        logic [W-1:0] p;
        logic         ordy;
        logic         fl;
        logic         e_ir;
        logic         e_ov;
        logic [W-1:0] e_op;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_payload = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_payload;
    logic         flush = 1'b0;
    logic [31:0]  stat_stall_cnt;
    logic [31:0]  stat_flush_cnt;

    int tests = 0;
    int fails = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_payload     (in_payload),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_payload    (out_payload),
        .flush          (flush),
        .stat_stall_cnt (stat_stall_cnt),
        .stat_flush_cnt (stat_flush_cnt)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [W-1:0] p, input logic ordy, input logic fl,
                       input logic e_ir, input logic e_ov, input logic [W-1:0] e_op);
        vec_t v;
        v.iv = iv; v.p = p; v.ordy = ordy; v.fl = fl;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_op = e_op;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] p, input logic ordy, input logic fl);
        in_valid = iv; in_payload = p; out_ready = ordy; flush = fl;
    endtask

    initial begin
        logic [31:0] exp_stall;
        logic [31:0] exp_flush;
`ifdef PIPE_STAGE_STATS_EN
        exp_stall = 32'd5;
        exp_flush = 32'd2;
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        // streaming
        add(1, 'h1, 1, 0, 1, 1, 'h1);
        add(1, 'h2, 1, 0, 1, 1, 'h2);
        add(1, 'h3, 1, 0, 1, 1, 'h3);
        add(0, 'h0, 1, 0, 1, 0, 'h0);
        // stall into skid, then drain in order
        add(1, 'hA, 1, 0, 1, 1, 'hA);
        add(1, 'hB, 0, 0, 0, 1, 'hA);
        add(1, 'hB, 0, 0, 0, 1, 'hA);
        add(0, 'h0, 1, 0, 1, 1, 'hB);
        add(0, 'h0, 1, 0, 1, 0, 'h0);
        // flush while skid is occupied, with an incoming word
        add(1, 'hA, 0, 0, 1, 1, 'hA);
        add(1, 'hB, 0, 0, 0, 1, 'hA);
        add(1, 'hC, 0, 1, 1, 0, 'h0);
        add(0, 'h0, 1, 0, 1, 0, 'h0);
        // empty stage with out_ready toggling
        add(0, 'h0, 0, 0, 1, 0, 'h0);
        add(0, 'h0, 1, 0, 1, 0, 'h0);
        add(0, 'h0, 0, 0, 1, 0, 'h0);
        // stalled full stage flushed, then flush of an empty stage
        add(1, 'hD, 0, 0, 1, 1, 'hD);
        add(0, 'h0, 0, 1, 1, 0, 'h0);
        add(0, 'h0, 1, 1, 1, 0, 'h0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", W'(in_ready), W'(1));
        chk("reset out_valid", W'(out_valid), W'(0));
        chk("reset out_payload", out_payload, '0);
        chk("reset stall_cnt", W'(stat_stall_cnt), '0);
        chk("reset flush_cnt", W'(stat_flush_cnt), '0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].p, vecs[i].ordy, vecs[i].fl);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d in_ready", i), W'(in_ready), W'(vecs[i].e_ir));
            chk($sformatf("v%0d out_valid", i), W'(out_valid), W'(vecs[i].e_ov));
            chk($sformatf("v%0d out_payload", i), out_payload, vecs[i].e_op);
        end
        chk("stall_cnt", W'(stat_stall_cnt), W'(exp_stall));
        chk("flush_cnt", W'(stat_flush_cnt), W'(exp_flush));

        // asynchronous reset between edges while FULL
        drive(1, 'h55, 0, 0);
        @(posedge clk);
        #1;
        drive(0, 'h0, 0, 0);
        chk("pre-reset out_valid", W'(out_valid), W'(1));
        chk("pre-reset out_payload", out_payload, W'('h55));
        reset = 1'b1;
        #2;
        chk("async reset out_valid", W'(out_valid), W'(0));
        chk("async reset out_payload", out_payload, '0);
        chk("async reset in_ready", W'(in_ready), W'(1));
        chk("async reset stall_cnt", W'(stat_stall_cnt), '0);
        reset = 1'b0;
        drive(1, 'h66, 1, 0);
        @(posedge clk);
        #1;
        chk("post-reset out_valid", W'(out_valid), W'(1));
        chk("post-reset out_payload", out_payload, W'('h66));
        drive(0, 'h0, 1, 0);
        @(posedge clk);
        #1;
        chk("post-reset drain", W'(out_valid), W'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register: the successor to the fixed per-stage registers (F/D, D/E, E/M, M/W).
- Carries an opaque payload with a valid/ready handshake, flush (bubble insertion) and a one-entry skid buffer.
- The skid buffer keeps in_ready a registered signal, so stall does not form a combinational path across stages.
- Sits between any two datapath stages; the hazard unit drives out_ready (stall) and flush.

Parameters:
- PAYLOAD_W, 129: payload width in bits. 129 = instr + ALU result + rt + pc + cmp bit.
- BUBBLE_VAL, 0: value driven on out_payload when out_valid=0. Also the payload register reset value; all-zero = nop.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  upstream offers in_payload.
- in_ready  out  1  stage can accept; registered output.
- in_payload  in  PAYLOAD_W  upstream data.
- out_valid  out  1  out_payload holds a real instruction.
- out_ready  in  1  downstream accepts; 0 = stall.
- out_payload  out  PAYLOAD_W  stage output; BUBBLE_VAL when out_valid=0.
- flush  in  1  synchronous kill of all held and incoming entries.
- stat_stall_cnt  out  32  see Optional Feature.
- stat_flush_cnt  out  32  see Optional Feature.

Behaviour:
- Handshake: accept = in_valid & in_ready; emit = out_valid & out_ready; both evaluated at the rising clk edge. Payload must be stable while valid is high and ready is low.
- Storage: main register (drives out_payload) plus one skid register.
- States:
  - EMPTY (nothing held): in_ready=1, out_valid=0.
  - FULL (main only): in_ready=1, out_valid=1.
  - SKID (main + skid): in_ready=0, out_valid=1.
- Transitions, when flush=0:
  - EMPTY, accept → FULL, main<=in.
  - FULL, accept & emit → FULL, main<=in.
  - FULL, accept & !emit → SKID, skid<=in.
  - FULL, !accept & emit → EMPTY.
  - SKID, emit → FULL, main<=skid.
  - Any other combination: hold.
- Latency: one cycle from accept to out_valid. Throughput: one per cycle while out_ready=1.
- Ordering: strictly FIFO; the skid entry is never emitted before main.
- Flush has highest priority:
  - Next state EMPTY; main and skid <= BUBBLE_VAL.
  - A word accepted in the same cycle is discarded; upstream treats it as consumed.
  - Flush with out_ready=1 still counts as an emit of the current main.
- Reset values: in_ready=1, out_valid=0, out_payload=BUBBLE_VAL, counters=0, state EMPTY. Reset asserted mid-operation drops all entries asynchronously.
- out_payload is forced to BUBBLE_VAL whenever out_valid=0, regardless of main register contents.
- in_ready depends only on state registers and never on out_ready in the same cycle.

Optional Feature:
- Macro PIPE_STAGE_STATS_EN.
- Defined:
  - stat_stall_cnt increments every cycle with out_valid=1 & out_ready=0.
  - stat_flush_cnt increments every cycle with flush=1 while state≠EMPTY.
  - Both saturate at 32'hFFFF_FFFF and clear only on reset.
- Undefined: both ports are tied to 0; no counter logic is synthesised. The port list is identical in both builds.

Decomposition:
- Package pipe_pkg holds:
  - the state typedef (EMPTY/FULL/SKID, 2-bit);
  - the E/M payload field widths and offsets (INSTR, ALU, RT, PC, CMP) and the resulting PAYLOAD_W constant;
  - the NOP constant used as BUBBLE_VAL.
- One sub-module, pipe_sat_counter (32-bit saturating counter with enable), instantiated twice under PIPE_STAGE_STATS_EN.

Test Plan:
- Streaming: out_ready=1; push payloads 1,2,3 on consecutive cycles → out_payload 1,2,3 one cycle later, out_valid held 3 cycles, in_ready stays 1.
- Stall into skid: push 0xA; set out_ready=0; push 0xB → in_ready=0 next cycle, out_payload=0xA. Release out_ready → 0xA then 0xB emitted in order, in_ready=1 after 0xA leaves.
- Flush while SKID holds 0xA/0xB, in_valid=1 with 0xC → next cycle out_valid=0, out_payload=0, in_ready=1; 0xC never appears.
- Async reset pulse mid-cycle while FULL → out_valid drops to 0 before the next clk edge, out_payload=0; first push after reset emits normally.
- Empty stage: in_valid=0, out_ready toggling → out_valid stays 0, out_payload stays BUBBLE_VAL.
- Stats build: 5 stall cycles plus 2 flushes of a non-empty stage → stat_stall_cnt=5, stat_flush_cnt=2. Non-stats build → both counters read 0.
